multi_clock_generator: RTL and testbench
========================================

# multi_clock_generator

Multi-channel programmable clock generator: derives nrOfChannels independent slow clocks from globalClock, each with run-time high/low tick counts and an enable. Period changes are glitch-free: they take effect only at a period boundary. It sits between the board-level tick divider and the circuit's clocked components. Each channel drives a 4-bit clock bundle (level, inverted level, rising pulse, falling pulse); globalClock is appended as the top bit of the bus.

## Interface
- chanBits, 2, log2 of channel count; nrOfChannels = 2**chanBits
- nrOfBits, 8, width of the high/low tick counters and config fields
- globalClock  in  1  sole clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- clockTick  in  1  tick enable; counters advance only when high
- syncStart  in  1  restarts all channels in phase
- cfgWrite  in  1  writes the config fields into shadow[cfgChannel]
- cfgChannel  in  chanBits  target channel of a config write
- cfgHigh  in  nrOfBits  high-phase length in ticks; 0 is treated as 1
- cfgLow  in  nrOfBits  low-phase length in ticks; 0 is treated as 1
- cfgEnable  in  1  channel enable
- clockBus  out  4*nrOfChannels+1  channel c bits [4c+3:4c] = {fallPulse, risePulse, ~level, level}; MSB = globalClock
- cfgPending  out  nrOfChannels  shadow config not yet loaded into active config

## Operation
- Per channel state:
  - shadow regs sHigh, sLow, sEn.
  - active regs aHigh, aLow.
  - level L, counter cnt[nrOfBits-1:0].
  - output regs o[3:0].
- Reset values: L=0, cnt=0, sHigh=sLow=aHigh=aLow=1, sEn=0, o=4'b0010. Resulting outputs: clockBus channel bits 0010 each; cfgPending=0.
- Config write (cfgWrite=1): shadow[cfgChannel] <= {cfgHigh, cfgLow, cfgEnable} at the edge. Zero lengths are stored as 1.
- Priority per edge: reset > syncStart > disabled > clockTick.
- syncStart=1, regardless of clockTick: every channel L<=0, cnt<=0, active<=shadow.
- Disabled channel (sEn=0): L<=0, cnt<=0, active<=shadow every cycle.
- Enabled channel, clockTick=1:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0 and L=0: L<=1, cnt<=hSel-1. hSel = sHigh if loading this edge, else aHigh.
  - If cnt==0 and L=1: L<=0, cnt<=aLow-1.
- Active load: at each 0->1 toggle, active<=shadow. The new high length applies to the high phase that starts this edge. Lengths are thereby constant within a period.
- Enabled channel, clockTick=0: hold all state.
- Shadow values used in any load are the pre-edge values. A cfgWrite on a load edge lands in shadow and applies at the next boundary.
- Resulting waveform: L is high for aHigh ticks and low for aLow ticks. The first rising edge of L occurs on the first tick after enable or syncStart.
- Output stage, every edge: o0<=L, o1<=~L, o2<=L&~o0, o3<=~L&o0.
- cfgPending[c] = (sHigh!=aHigh) | (sLow!=aLow), combinational.

## Timing
- level/~level: 1 globalClock cycle after the L update.
- Rise/fall pulses: exactly 1 globalClock cycle wide, asserted in the same cycle o0 changes.
- No pulses while L is static.
- Disabling a high channel: L=0 next edge, and a fall pulse is produced.
- syncStart while L=1: a fall pulse on every channel that was high.
- Counter arithmetic: nrOfBits unsigned. Maximum length 2**nrOfBits-1 ticks. No wrap, because cnt is only decremented from nonzero values.
- Asynchronous reset mid-period: outputs go to reset values immediately. Restart on the first tick after reset deasserts.

## Test plan
- Reset: assert reset mid-run -> clockBus per channel = 0010 immediately; cfgPending=0.
- Basic period: clockTick=1, ch0 high=2 low=3 enable -> o0 pattern 1,1,0,0,0 repeating with period 5; rise pulse every 5 cycles; fall pulse 2 cycles after each rise.
- Tick gating: clockTick high every 4th cycle, ch1 high=1 low=1 -> o0 toggles every 4 cycles; pulses are 1 cycle wide.
- Glitch-free change: ch0 running 2/3; write high=4 low=1 mid-high-phase -> cfgPending[0]=1; current period completes as 2/3; next period is 4/1; cfgPending clears at the load edge.
- syncStart: ch0=3/3, ch2=1/5 at arbitrary phases; pulse syncStart -> both rise pulses occur in the same cycle on the next tick.
- Zero/disable: write ch3 high=0 low=0 -> behaves as 1/1. Disable while high -> one fall pulse, then o0 stays 0.

Source files
------------

// File: rtl/multi_clock_generator.sv
// Programmable multi-channel clock generator: each channel derives a slow clock from
// globalClock ticks with independent high/low lengths, reloaded only at period boundaries.
module multi_clock_generator #(
  parameter  int chanBits     = 2,
  parameter  int nrOfBits     = 8,
  localparam int nrOfChannels = 1 << chanBits
) (
  input  logic                          globalClock,
  input  logic                          reset,
  input  logic                          clockTick,
  input  logic                          syncStart,
  input  logic                          cfgWrite,
  input  logic [chanBits-1:0]           cfgChannel,
  input  logic [nrOfBits-1:0]           cfgHigh,
  input  logic [nrOfBits-1:0]           cfgLow,
  input  logic                          cfgEnable,
  output logic [4*nrOfChannels:0]       clockBus,
  output logic [nrOfChannels-1:0]       cfgPending
);

  logic [nrOfBits-1:0]     sHigh [nrOfChannels];
  logic [nrOfBits-1:0]     sLow  [nrOfChannels];
  logic [nrOfBits-1:0]     aHigh [nrOfChannels];
  logic [nrOfBits-1:0]     aLow  [nrOfChannels];
  logic [nrOfBits-1:0]     cnt   [nrOfChannels];
  logic [3:0]              o     [nrOfChannels];
  logic [nrOfChannels-1:0] sEn;
  logic [nrOfChannels-1:0] level;

  // A zero length would make a phase vanish; it is stored as a one-tick phase instead.
  function automatic logic [nrOfBits-1:0] fixLen(input logic [nrOfBits-1:0] v);
    return (v == '0) ? nrOfBits'(1) : v;
  endfunction

  // NOTE: every register here uses non-blocking assignment, so all channels and the
  // output stage see the same pre-edge values regardless of statement order.
  always_ff @(posedge globalClock or posedge reset) begin
    if (reset) begin
      // NOTE: the config register arrays are reset too; their reset value (length 1,
      // disabled) is visible on cfgPending and the bus, so they cannot be left unknown.
      for (int c = 0; c < nrOfChannels; c++) begin
        sHigh[c] <= nrOfBits'(1);
        sLow[c]  <= nrOfBits'(1);
        aHigh[c] <= nrOfBits'(1);
        aLow[c]  <= nrOfBits'(1);
        cnt[c]   <= '0;
        o[c]     <= 4'b0010;
      end
      sEn   <= '0;
      level <= '0;
    end else begin
      for (int c = 0; c < nrOfChannels; c++) begin
        if (cfgWrite && cfgChannel == chanBits'(c)) begin
          sHigh[c] <= fixLen(cfgHigh);
          sLow[c]  <= fixLen(cfgLow);
          sEn[c]   <= cfgEnable;
        end

        if (syncStart || !sEn[c]) begin
          level[c] <= 1'b0;
          cnt[c]   <= '0;
          aHigh[c] <= sHigh[c];
          aLow[c]  <= sLow[c];
        end else if (clockTick) begin
          if (cnt[c] != '0) begin
            cnt[c] <= cnt[c] - 1'b1;
          end else if (!level[c]) begin
            // Period boundary: the new high length governs the phase starting now.
            level[c] <= 1'b1;
            cnt[c]   <= sHigh[c] - 1'b1;
            aHigh[c] <= sHigh[c];
            aLow[c]  <= sLow[c];
          end else begin
            level[c] <= 1'b0;
            cnt[c]   <= aLow[c] - 1'b1;
          end
        end

        o[c] <= {~level[c] & o[c][0], level[c] & ~o[c][0], ~level[c], level[c]};
      end
    end
  end

  // NOTE: outputs of always_comb get a default first so no path leaves them unassigned.
  always_comb begin
    cfgPending = '0;
    for (int c = 0; c < nrOfChannels; c++)
      cfgPending[c] = (sHigh[c] != aHigh[c]) || (sLow[c] != aLow[c]);
  end

  always_comb begin
    clockBus = '0;
    for (int c = 0; c < nrOfChannels; c++)
      clockBus[4*c +: 4] = o[c];
    clockBus[4*nrOfChannels] = globalClock;
  end

endmodule

// File: tb/tb_multi_clock_generator.sv
// Bench for multi_clock_generator: period-position reference model compared every cycle,
// plus hand-derived waveform vectors for the directed scenarios.
module tb_multi_clock_generator;

  localparam int NCH = 4;

  logic        globalClock = 1'b0;
  logic        reset       = 1'b0;
  logic        clockTick   = 1'b0;
  logic        syncStart   = 1'b0;
  logic        cfgWrite    = 1'b0;
  logic [1:0]  cfgChannel  = '0;
  logic [7:0]  cfgHigh     = '0;
  logic [7:0]  cfgLow      = '0;
  logic        cfgEnable   = 1'b0;
  logic [16:0] clockBus;
  logic [3:0]  cfgPending;

  int errors = 0;
  int checks = 0;

  multi_clock_generator dut (
    .globalClock(globalClock),
    .reset      (reset),
    .clockTick  (clockTick),
    .syncStart  (syncStart),
    .cfgWrite   (cfgWrite),
    .cfgChannel (cfgChannel),
    .cfgHigh    (cfgHigh),
    .cfgLow     (cfgLow),
    .cfgEnable  (cfgEnable),
    .clockBus   (clockBus),
    .cfgPending (cfgPending)
  );

  always #5 globalClock = ~globalClock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel tracks its position t within the current period;
  // the level is high for the first aH positions of an aH+aL long period.
  int mSH[NCH], mSL[NCH], mAH[NCH], mAL[NCH], mT[NCH];
  bit mEn[NCH], mRun[NCH], mL[NCH], p1[NCH], p2[NCH];

  always @(posedge globalClock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        mSH[c] = 1; mSL[c] = 1; mAH[c] = 1; mAL[c] = 1; mT[c] = 0;
        mEn[c] = 0; mRun[c] = 0; mL[c] = 0; p1[c] = 0; p2[c] = 0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        p2[c] = p1[c];
        p1[c] = mL[c];
        if (syncStart || !mEn[c]) begin
          mRun[c] = 0; mL[c] = 0; mAH[c] = mSH[c]; mAL[c] = mSL[c];
        end else if (clockTick) begin
          if (!mRun[c] || mT[c] == mAH[c] + mAL[c] - 1) begin
            mAH[c] = mSH[c]; mAL[c] = mSL[c]; mT[c] = 0; mRun[c] = 1;
          end else begin
            mT[c]++;
          end
          mL[c] = (mT[c] < mAH[c]);
        end
      end
      if (cfgWrite) begin
        mSH[cfgChannel] = (cfgHigh == 0) ? 1 : int'(cfgHigh);
        mSL[cfgChannel] = (cfgLow == 0) ? 1 : int'(cfgLow);
        mEn[cfgChannel] = cfgEnable;
      end
    end
  end

  function automatic logic [16:0] modelBus();
    logic [16:0] b;
    b = '0;
    for (int c = 0; c < NCH; c++)
      b[4*c +: 4] = {~p1[c] & p2[c], p1[c] & ~p2[c], ~p1[c], p1[c]};
    b[16] = globalClock;
    return b;
  endfunction

  function automatic logic [3:0] modelPending();
    logic [3:0] p;
    for (int c = 0; c < NCH; c++) p[c] = (mSH[c] != mAH[c]) || (mSL[c] != mAL[c]);
    return p;
  endfunction

  always @(negedge globalClock) begin
    if (!reset) begin
      check("model bus", 32'(clockBus), 32'(modelBus()));
      check("model cfgPending", 32'(cfgPending), 32'(modelPending()));
    end
  end

  task automatic tickEdge();
    @(posedge globalClock);
    #1;
  endtask

  task automatic setCfg(input int ch, input int hi, input int lo, input logic en);
    cfgWrite = 1'b1; cfgChannel = 2'(ch); cfgHigh = 8'(hi); cfgLow = 8'(lo); cfgEnable = en;
  endtask

  function automatic logic bitOf(input int ch, input int k);
    return clockBus[4*ch + k];
  endfunction

  logic [15:0] v0, v2, v3;

  initial begin
    #1 reset = 1'b1;
    #2;
    check("reset bus", 32'(clockBus), 32'h0_2222);
    check("reset pending", 32'(cfgPending), 32'h0);
    #9 reset = 1'b0;

    // Basic period: ch0 2/3 with a tick every cycle.
    clockTick = 1'b1;
    setCfg(0, 2, 3, 1'b1);
    tickEdge();
    cfgWrite = 1'b0;
    v0 = '0; v2 = '0; v3 = '0;
    for (int i = 0; i < 10; i++) begin
      tickEdge();
      v0 = {v0[14:0], bitOf(0, 0)};
      v2 = {v2[14:0], bitOf(0, 2)};
      v3 = {v3[14:0], bitOf(0, 3)};
    end
    check("basic level", 32'(v0[9:0]), 32'b0110001100);
    check("basic rise", 32'(v2[9:0]), 32'b0100001000);
    check("basic fall", 32'(v3[9:0]), 32'b0001000010);

    // Glitch-free change: write 4/1 during the high phase after a restart.
    syncStart = 1'b1;
    tickEdge();
    syncStart = 1'b0;
    tickEdge();
    setCfg(0, 4, 1, 1'b1);
    v0 = '0; v2 = '0;
    for (int i = 0; i < 11; i++) begin
      tickEdge();
      cfgWrite = 1'b0;
      v0 = {v0[14:0], bitOf(0, 0)};
      v2 = {v2[14:0], cfgPending[0]};
    end
    check("change level", 32'(v0[10:0]), 32'b11000111101);
    check("change pending", 32'(v2[10:0]), 32'b11110000000);

    // Tick gating: ch1 1/1 with a tick every 4th cycle.
    clockTick = 1'b0;
    setCfg(1, 1, 1, 1'b1);
    tickEdge();
    cfgWrite = 1'b0;
    v0 = '0; v2 = '0;
    for (int i = 0; i < 12; i++) begin
      clockTick = (i % 4 == 0);
      tickEdge();
      v0 = {v0[14:0], bitOf(1, 0)};
      v2 = {v2[14:0], bitOf(1, 2)};
    end
    check("gated level", 32'(v0[11:0]), 32'b011110000111);
    check("gated rise", 32'(v2[11:0]), 32'b010000000100);

    // syncStart: ch0 3/3 and ch2 1/5 at arbitrary phases rise together.
    clockTick = 1'b0;
    setCfg(0, 3, 3, 1'b1);
    tickEdge();
    setCfg(2, 1, 5, 1'b1);
    tickEdge();
    cfgWrite = 1'b0;
    clockTick = 1'b1;
    repeat ($urandom_range(5, 15)) tickEdge();
    clockTick = 1'b0;
    syncStart = 1'b1;
    tickEdge();
    syncStart = 1'b0;
    tickEdge();
    clockTick = 1'b1;
    tickEdge();
    check("sync no early rise", 32'({bitOf(2, 2), bitOf(0, 2)}), 32'b00);
    clockTick = 1'b0;
    tickEdge();
    check("sync joint rise", 32'({bitOf(2, 2), bitOf(0, 2)}), 32'b11);

    // Zero lengths act as 1/1; disabling while high gives a single fall pulse.
    clockTick = 1'b1;
    setCfg(3, 0, 0, 1'b1);
    tickEdge();
    cfgWrite = 1'b0;
    check("zero length pending", 32'(cfgPending[3]), 32'h0);
    v0 = '0; v3 = '0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        clockTick = 1'b0;
        setCfg(3, 1, 1, 1'b0);
      end
      tickEdge();
      cfgWrite = 1'b0;
      v0 = {v0[14:0], bitOf(3, 0)};
      v3 = {v3[14:0], bitOf(3, 3)};
    end
    check("disable level", 32'(v0[9:0]), 32'b0101011000);
    check("disable fall", 32'(v3[9:0]), 32'b0010100100);

    // Randomized traffic with one asynchronous reset mid-run.
    for (int i = 0; i < 2500; i++) begin
      clockTick  = ($urandom % 3) != 0;
      syncStart  = ($urandom % 64) == 0;
      cfgWrite   = ($urandom % 6) == 0;
      cfgChannel = 2'($urandom);
      cfgHigh    = 8'($urandom_range(0, 5));
      cfgLow     = 8'($urandom_range(0, 5));
      cfgEnable  = ($urandom % 8) != 0;
      tickEdge();
      if (i == 1200) begin
        #2 reset = 1'b1;
        #1;
        check("mid-run reset bus", 32'(clockBus), 32'h1_2222);
        check("mid-run reset pending", 32'(cfgPending), 32'h0);
        #2 reset = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
